// File: rtl/fir_bridge_pkg.sv
// Shared constants for the Wishbone <-> FIR stream bridge: register offsets,
// Wishbone cycle-type codes, STATUS bit positions and the bus FSM encoding.
package fir_bridge_pkg;

    localparam logic [7:0] OFF_STATUS = 8'h00;
    localparam logic [7:0] OFF_LEN    = 8'h10;
    localparam logic [7:0] OFF_X      = 8'h80;
    localparam logic [7:0] OFF_Y      = 8'h84;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam int ST_IN_EMPTY     = 0;
    localparam int ST_IN_FULL      = 1;
    localparam int ST_OUT_NONEMPTY = 2;
    localparam int ST_LAST_SEEN    = 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_WAIT
    } wb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Register-based synchronous FIFO with full/empty flags, occupancy count and
// same-cycle push/pop (a push into a full FIFO is allowed when it also pops).
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       din_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       dout_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic [AW:0]      cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/wb_fir_stream_bridge.sv
// Wishbone slave that pushes firmware writes into the FIR AXI-Stream input,
// frames them with tlast from a programmed length, and drains FIR output.
module wb_fir_stream_bridge
    import fir_bridge_pkg::*;
#(
    parameter int          DATA_W     = 32,
    parameter int          FIFO_DEPTH = 4,
    parameter int          LEN_W      = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [2:0]        wbs_cti_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [DATA_W-1:0] wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [DATA_W-1:0] wbs_dat_o,
    output logic [DATA_W-1:0] ss_tdata,
    output logic              ss_tvalid,
    output logic              ss_tlast,
    input  logic              ss_tready,
    input  logic [DATA_W-1:0] sm_tdata,
    input  logic              sm_tvalid,
    input  logic              sm_tlast,
    output logic              sm_tready,
    output logic              frame_done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LEN_W-1:0] LEN_ONE = 1;

    wb_state_e        state_q, state_d;
    logic [LEN_W-1:0] len_q, len_act_q, len_cur, len_m1;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             last_seen_q, last_seen_d;
    logic             frame_done_q;

    logic [DATA_W-1:0] in_head;
    logic [DATA_W:0]   out_head;
    logic              in_full, in_empty, out_full, out_empty;
    logic [CW-1:0]     in_cnt, out_cnt, in_cnt_nxt, out_cnt_nxt;

    logic       hit, req, sel_full, is_x, is_y, res_ok, next_ok;
    logic [7:0] off;
    logic       x_push, y_pop, ss_pop, sm_push, len_wr, stat_clr;

    assign off      = wbs_adr_i[7:0];
    assign hit      = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req      = wbs_cyc_i && wbs_stb_i && hit;
    assign sel_full = &wbs_sel_i;
    assign is_x     = wbs_we_i && (off == OFF_X);
    assign is_y     = !wbs_we_i && (off == OFF_Y);
    assign res_ok   = is_x ? !in_full : (is_y ? !out_empty : 1'b1);

    // A beat completes on the edge that ends its ack cycle; side effects happen there.
    assign wbs_ack_o = (state_q == S_ACK) && wbs_cyc_i && wbs_stb_i && !wb_rst_i;
    assign x_push    = wbs_ack_o && is_x && sel_full;
    assign y_pop     = wbs_ack_o && is_y && sel_full;
    assign len_wr    = wbs_ack_o && wbs_we_i && (off == OFF_LEN);
    assign stat_clr  = wbs_ack_o && wbs_we_i && (off == OFF_STATUS) && wbs_dat_i[ST_LAST_SEEN];

    assign ss_tvalid = !in_empty && !wb_rst_i;
    assign ss_tdata  = in_head;
    assign ss_pop    = ss_tvalid && ss_tready;
    assign sm_tready = !out_full && !wb_rst_i;
    assign sm_push   = sm_tvalid && sm_tready;
    assign frame_done = frame_done_q;

    // Burst continuation is granted ahead of time from post-edge occupancy,
    // assuming the next beat targets the same data port.
    assign in_cnt_nxt  = in_cnt + CW'(x_push) - CW'(ss_pop);
    assign out_cnt_nxt = out_cnt - CW'(y_pop) + CW'(sm_push);
    assign next_ok = is_x ? (in_cnt_nxt < CW'(FIFO_DEPTH))
                          : (is_y ? (out_cnt_nxt != '0) : 1'b1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (req && res_ok) state_d = S_ACK;
            S_ACK: begin
                if (!(wbs_cyc_i && wbs_stb_i))  state_d = S_IDLE;
                else if (wbs_cti_i == CTI_INCR) state_d = next_ok ? S_ACK : S_WAIT;
                else                            state_d = S_IDLE;
            end
            S_WAIT: begin
                if (!wbs_cyc_i)          state_d = S_IDLE;
                else if (req && res_ok)  state_d = S_ACK;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new length is only adopted at a frame boundary (counter at zero).
    assign len_cur   = (cnt_q == '0) ? len_q : len_act_q;
    assign len_m1    = (len_cur == '0) ? '0 : len_cur - LEN_ONE;
    assign ss_tlast  = ss_tvalid && (cnt_q == len_m1);

    always_comb begin
        cnt_d = cnt_q;
        if (ss_pop) cnt_d = (cnt_q == len_m1) ? '0 : cnt_q + LEN_ONE;
        last_seen_d = last_seen_q;
        if (stat_clr) last_seen_d = 1'b0;
        if (y_pop && out_head[DATA_W]) last_seen_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            len_act_q    <= '0;
            cnt_q        <= '0;
            last_seen_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_seen_q  <= last_seen_d;
            frame_done_q <= y_pop && out_head[DATA_W];
            if (len_wr)         len_q     <= wbs_dat_i[LEN_W-1:0];
            if (cnt_q == '0)    len_act_q <= len_q;
        end
    end

    always_comb begin
        wbs_dat_o = '0;
        if (wbs_ack_o && !wbs_we_i) begin
            case (off)
                OFF_STATUS: begin
                    wbs_dat_o[ST_IN_EMPTY]     = in_empty;
                    wbs_dat_o[ST_IN_FULL]      = in_full;
                    wbs_dat_o[ST_OUT_NONEMPTY] = !out_empty;
                    wbs_dat_o[ST_LAST_SEEN]    = last_seen_q;
                end
                OFF_LEN: wbs_dat_o[LEN_W-1:0] = len_q;
                OFF_Y:   if (sel_full) wbs_dat_o = out_head[DATA_W-1:0];
                default: wbs_dat_o = '0;
            endcase
        end
    end

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (x_push),
        .din_i   (wbs_dat_i),
        .pop_i   (ss_pop),
        .dout_o  (in_head),
        .full_o  (in_full),
        .empty_o (in_empty),
        .count_o (in_cnt)
    );

    sync_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (sm_push),
        .din_i   ({sm_tlast, sm_tdata}),
        .pop_i   (y_pop),
        .dout_o  (out_head),
        .full_o  (out_full),
        .empty_o (out_empty),
        .count_o (out_cnt)
    );

endmodule

// File: tb/tb_wb_fir_stream_bridge.sv
// Directed bench for wb_fir_stream_bridge: Wishbone master tasks, stream-side
// monitor and hand-computed expected values.
module tb_wb_fir_stream_bridge;
    localparam int DATA_W = 32;
    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [31:0] A_STAT = BASE + 32'h00;
    localparam logic [31:0] A_LEN  = BASE + 32'h10;
    localparam logic [31:0] A_X    = BASE + 32'h80;
    localparam logic [31:0] A_Y    = BASE + 32'h84;

    logic              wb_clk_i = 1'b0;
    logic              wb_rst_i;
    logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
    logic [3:0]        wbs_sel_i;
    logic [2:0]        wbs_cti_i;
    logic [31:0]       wbs_adr_i;
    logic [DATA_W-1:0] wbs_dat_i;
    logic              wbs_ack_o;
    logic [DATA_W-1:0] wbs_dat_o;
    logic [DATA_W-1:0] ss_tdata;
    logic              ss_tvalid, ss_tlast, ss_tready;
    logic [DATA_W-1:0] sm_tdata;
    logic              sm_tvalid, sm_tlast, sm_tready;
    logic              frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    int bad_ack = 0;
    logic [DATA_W:0] stream_q[$];

    wb_fir_stream_bridge dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_cti_i (wbs_cti_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .ss_tdata  (ss_tdata),
        .ss_tvalid (ss_tvalid),
        .ss_tlast  (ss_tlast),
        .ss_tready (ss_tready),
        .sm_tdata  (sm_tdata),
        .sm_tvalid (sm_tvalid),
        .sm_tlast  (sm_tlast),
        .sm_tready (sm_tready),
        .frame_done(frame_done)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    always @(negedge wb_clk_i) begin
        if (!wb_rst_i && ss_tvalid && ss_tready) stream_q.push_back({ss_tlast, ss_tdata});
        if (frame_done) fd_cnt++;
        if (wbs_ack_o && !wbs_cyc_i) bad_ack++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] cti_for(input int b, input int n);
        if (n == 1)     return 3'b000;
        if (b == n - 1) return 3'b111;
        return 3'b010;
    endfunction

    task automatic bus_idle();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
        wbs_sel_i = 4'h0; wbs_cti_i = 3'b000;
        @(posedge wb_clk_i); #1;
    endtask

    // Write burst of n beats d0, d0+1, ...; drops cyc after 'stop' acks or 'budget' cycles.
    task automatic wb_burst_wr(input logic [31:0] adr, input logic [31:0] d0, input int n,
                               input int stop, input int budget, output int acks);
        int beat;
        beat = 0;
        acks = 0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = adr; wbs_dat_i = d0; wbs_cti_i = cti_for(0, n);
        for (int c = 0; c < budget && acks < stop; c++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) begin
                acks++;
                beat++;
            end
            @(posedge wb_clk_i); #1;
            wbs_dat_i = d0 + beat;
            wbs_cti_i = cti_for(beat, n);
        end
        bus_idle();
    endtask

    task automatic wb_wr(input logic [31:0] adr, input logic [31:0] d, input string tag);
        int acks;
        wb_burst_wr(adr, d, 1, 1, 6, acks);
        chk(tag, acks, 1);
    endtask

    task automatic wb_rd(input logic [31:0] adr, input int budget,
                         output logic [31:0] d, output bit got);
        got = 1'b0;
        d = '0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = adr; wbs_cti_i = 3'b000;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge wb_clk_i);
            if (wbs_ack_o) begin
                got = 1'b1;
                d = wbs_dat_o;
            end
            @(posedge wb_clk_i); #1;
        end
        bus_idle();
    endtask

    task automatic rd_chk(input logic [31:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        bit got;
        wb_rd(adr, 8, d, got);
        chk({tag, "_ack"}, got, 1);
        chk(tag, d, exp);
    endtask

    task automatic sm_push(input logic [31:0] d, input logic last);
        sm_tvalid = 1'b1; sm_tdata = d; sm_tlast = last;
        @(negedge wb_clk_i);
        chk("sm_tready", sm_tready, 1);
        @(posedge wb_clk_i); #1;
        sm_tvalid = 1'b0; sm_tlast = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        logic [31:0] d;
        bit got;

        wb_rst_i = 1'b1;
        wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_cti_i = 0;
        wbs_adr_i = 0; wbs_dat_i = 0;
        ss_tready = 0; sm_tdata = 0; sm_tvalid = 0; sm_tlast = 0;

        // Reset
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("rst_ack", wbs_ack_o, 0);
        chk("rst_dat", wbs_dat_o, 0);
        chk("rst_ss_tvalid", ss_tvalid, 0);
        chk("rst_ss_tlast", ss_tlast, 0);
        chk("rst_sm_tready", sm_tready, 0);
        chk("rst_frame_done", frame_done, 0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        rd_chk(A_STAT, 32'h1, "status_after_rst");

        // LEN = 4, 8-beat burst streamed out with tlast on samples 4 and 8
        wb_wr(A_LEN, 32'd4, "len_wr");
        rd_chk(A_LEN, 32'd4, "len_rd");
        ss_tready = 1'b1;
        stream_q.delete();
        wb_burst_wr(A_X, 32'd1, 8, 8, 20, acks);
        chk("burst8_acks", acks, 8);
        repeat (4) @(posedge wb_clk_i); #1;
        chk("burst8_count", stream_q.size(), 8);
        for (int i = 0; i < 8 && i < stream_q.size(); i++)
            chk($sformatf("burst8_s%0d", i), stream_q[i], {(i % 4 == 3), 32'(i + 1)});

        // Stall with ss_tready low: 4 acks then wait states
        ss_tready = 1'b0;
        stream_q.delete();
        wb_burst_wr(A_X, 32'h10, 6, 6, 10, acks);
        chk("stall_acks", acks, 4);
        rd_chk(A_STAT, 32'h2, "status_in_full");
        chk("stall_no_pop", stream_q.size(), 0);
        ss_tready = 1'b1;
        wb_burst_wr(A_X, 32'h14, 2, 2, 10, acks);
        chk("resume_acks", acks, 2);
        repeat (6) @(posedge wb_clk_i); #1;
        chk("stall_count", stream_q.size(), 6);
        for (int i = 0; i < 6 && i < stream_q.size(); i++)
            chk($sformatf("stall_s%0d", i), stream_q[i], {(i == 3), 32'(32'h10 + i)});

        // Y read: empty gives no ack, then data with tlast from the FIR
        wb_rd(A_Y, 5, d, got);
        chk("y_empty_noack", got, 0);
        fd_cnt = 0;
        sm_push(32'h55, 1'b1);
        rd_chk(A_STAT, 32'h5, "status_out_nonempty");
        rd_chk(A_Y, 32'h55, "y_data");
        repeat (2) @(posedge wb_clk_i); #1;
        chk("frame_done_pulses", fd_cnt, 1);
        rd_chk(A_STAT, 32'h9, "status_last_seen");
        wb_wr(A_STAT, 32'h8, "status_w1c_wr");
        rd_chk(A_STAT, 32'h1, "status_after_w1c");

        // Abort after 2 beats of a 4-beat burst (counter resumes at 2 of LEN 4)
        stream_q.delete();
        wb_burst_wr(A_X, 32'h20, 4, 2, 10, acks);
        chk("abort_acks", acks, 2);
        chk("abort_ack_low", wbs_ack_o, 0);
        repeat (4) @(posedge wb_clk_i); #1;
        chk("abort_count", stream_q.size(), 2);
        if (stream_q.size() == 2) begin
            chk("abort_s0", stream_q[0], {1'b0, 32'h20});
            chk("abort_s1", stream_q[1], {1'b1, 32'h21});
        end

        // Reset in the middle of a burst with both FIFOs partly filled
        ss_tready = 1'b0;
        wb_burst_wr(A_X, 32'h30, 2, 2, 8, acks);
        chk("prefill_acks", acks, 2);
        sm_push(32'h61, 1'b0);
        sm_push(32'h62, 1'b0);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1; wbs_sel_i = 4'hF;
        wbs_adr_i = A_X; wbs_dat_i = 32'h40; wbs_cti_i = 3'b010;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        chk("pre_rst_ack", wbs_ack_o, 1);
        @(posedge wb_clk_i); #1;
        wbs_dat_i = 32'h41;
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        chk("rst_mid_ack", wbs_ack_o, 0);
        @(posedge wb_clk_i); #1;
        wb_rst_i = 1'b0;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0; wbs_cti_i = 3'b000;
        @(negedge wb_clk_i);
        chk("rst_mid_tvalid", ss_tvalid, 0);
        chk("rst_mid_sm_tready", sm_tready, 1);
        @(posedge wb_clk_i); #1;
        rd_chk(A_STAT, 32'h1, "rst_mid_status");
        rd_chk(A_LEN, 32'h0, "rst_mid_len");

        // LEN = 0 behaves as 1: every sample carries tlast
        ss_tready = 1'b1;
        stream_q.delete();
        wb_burst_wr(A_X, 32'h70, 2, 2, 8, acks);
        chk("len0_acks", acks, 2);
        repeat (4) @(posedge wb_clk_i); #1;
        chk("len0_count", stream_q.size(), 2);
        if (stream_q.size() == 2) begin
            chk("len0_s0", stream_q[0], {1'b1, 32'h70});
            chk("len0_s1", stream_q[1], {1'b1, 32'h71});
        end

        chk("ack_without_cyc", bad_ack, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
